// File: rtl/qtr_pkg.sv
// ---------------------------------------------------------------------------
// qtr_pkg
// Shared definitions for the QTR reflectance-array reader:
//   - default sizing/timing parameters (channel count, result width,
//     charge time and decay timeout, all in clk cycles)
//   - sweep FSM state encodings (IDLE, CHARGE, DECAY, DONE)
// No ports; imported by qtr_array_reader and qtr_channel_capture.
// ---------------------------------------------------------------------------
package qtr_pkg;

  localparam int N_CH_DEF        = 8;
  localparam int TTD_W_DEF       = 17;
  localparam int CHARGE_CYC_DEF  = 160;    // 10 us at 16 MHz
  localparam int TIMEOUT_CYC_DEF = 48000;  // 3 ms at 16 MHz

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHARGE = 2'd1;
  localparam logic [1:0] ST_DECAY  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/qtr_channel_capture.sv
// ---------------------------------------------------------------------------
// qtr_channel_capture
// One sensor channel: 2-FF synchronizer on the raw pin, a done flag and a
// time-to-decay capture register. The first synchronized low seen while armed
// records the shared decay count; a timeout records TIMEOUT_CYC and flags it.
// Ports:
//   clk, rst     clock, async active-high reset
//   clear        start of a new sweep: drop done/capture/flag
//   arm          channel is masked in and the sweep is in DECAY
//   cnt          shared decay counter value for this cycle
//   timeout_hit  decay counter has reached TIMEOUT_CYC this cycle
//   sensor_in    raw (asynchronous) pin level
//   done_d       next-state done flag (lets the top finish the sweep this cycle)
//   cap_d        next-state capture value
//   tflag_d      next-state timeout flag
// ---------------------------------------------------------------------------
module qtr_channel_capture
  import qtr_pkg::*;
#(
  parameter int TTD_W       = TTD_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             arm,
  input  logic [TTD_W-1:0] cnt,
  input  logic             timeout_hit,
  input  logic             sensor_in,
  output logic             done_d,
  output logic [TTD_W-1:0] cap_d,
  output logic             tflag_d
);

  localparam logic [TTD_W-1:0] TIMEOUT_VAL = TTD_W'(TIMEOUT_CYC);

  logic [1:0]       sync_q;
  logic             done_q;
  logic [TTD_W-1:0] cap_q;
  logic             tflag_q;
  logic             synced;

  assign synced = sync_q[1];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves it unassigned and a latch is never inferred.
  always_comb begin
    done_d  = done_q;
    cap_d   = cap_q;
    tflag_d = tflag_q;
    if (clear) begin
      done_d  = 1'b0;
      cap_d   = '0;
      tflag_d = 1'b0;
    end else if (arm && !done_q) begin
      // A real decay on the timeout cycle beats the timeout itself.
      if (!synced) begin
        done_d = 1'b1;
        cap_d  = cnt;
      end else if (timeout_hit) begin
        done_d  = 1'b1;
        cap_d   = TIMEOUT_VAL;
        tflag_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      done_q  <= 1'b0;
      cap_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sensor_in};
      done_q  <= done_d;
      cap_q   <= cap_d;
      tflag_q <= tflag_d;
    end
  end

endmodule

// File: rtl/qtr_array_reader.sv
// ---------------------------------------------------------------------------
// qtr_array_reader
// N-channel QTR reflectance-array reader. All masked channels are charged
// together for CHARGE_CYC cycles, then released; a shared decay counter
// timestamps each channel's synchronized falling edge (results include the
// fixed +2 cycle synchronizer latency). Sweeps end when every masked channel
// has decayed or the counter reaches TIMEOUT_CYC.
// Ports:
//   clk, rst       clock, async active-high reset
//   enable         block enable; low aborts any sweep
//   start          single-shot request pulse (ignored while busy)
//   continuous     auto-restart sweeps while enabled
//   ch_mask        per-channel enable, latched at each CHARGE entry
//   sensor_in      raw pin levels (asynchronous)
//   sensor_oe      1 = board top drives the pin high, 0 = tristate
//   ttd_flat       channel i result at [i*TTD_W +: TTD_W]
//   timeout_flags  channel i did not decay within TIMEOUT_CYC
//   sample_valid   1-cycle pulse coincident with new results
//   busy           FSM not in IDLE
//   led_even_en    any latched even channel active while busy
//   led_odd_en     any latched odd channel active while busy
// ---------------------------------------------------------------------------
module qtr_array_reader
  import qtr_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int TTD_W       = TTD_W_DEF,
  parameter int CHARGE_CYC  = CHARGE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic [N_CH-1:0]       sensor_in,
  output logic [N_CH-1:0]       sensor_oe,
  output logic [N_CH*TTD_W-1:0] ttd_flat,
  output logic [N_CH-1:0]       timeout_flags,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  led_even_en,
  output logic                  led_odd_en
);

  localparam logic [TTD_W-1:0] CHARGE_LAST = TTD_W'(CHARGE_CYC - 1);
  localparam logic [TTD_W-1:0] TIMEOUT_VAL = TTD_W'(TIMEOUT_CYC);

  logic [1:0]            state_q, state_d;
  logic [TTD_W-1:0]      cnt_q, cnt_d;
  logic [N_CH-1:0]       mask_q, mask_d;
  logic [N_CH*TTD_W-1:0] ttd_q;
  logic [N_CH-1:0]       tflag_q;
  logic                  valid_q;

  logic                  start_sweep;
  logic                  capture;
  logic                  timeout_hit;
  logic                  all_done;
  logic [N_CH-1:0]       done_d_vec;
  logic [N_CH-1:0]       tflag_d_vec;
  logic [N_CH*TTD_W-1:0] cap_d_flat;
  logic                  even_any, odd_any;

  // -------------------------------------------------------------------------
  // Per-channel synchronizer and capture
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    qtr_channel_capture #(
      .TTD_W       (TTD_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_cap (
      .clk         (clk),
      .rst         (rst),
      .clear       (start_sweep),
      .arm         ((state_q == ST_DECAY) && mask_q[i]),
      .cnt         (cnt_q),
      .timeout_hit (timeout_hit),
      .sensor_in   (sensor_in[i]),
      .done_d      (done_d_vec[i]),
      .cap_d       (cap_d_flat[i*TTD_W +: TTD_W]),
      .tflag_d     (tflag_d_vec[i])
    );
  end

  assign timeout_hit = (state_q == ST_DECAY) && (cnt_q == TIMEOUT_VAL);
  // Uses next-state done flags so the sweep ends on the same edge that
  // captures the last channel; unmasked channels count as done.
  assign all_done    = &(done_d_vec | ~mask_q);

  // -------------------------------------------------------------------------
  // Sweep FSM and shared charge/decay counter
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    start_sweep = 1'b0;
    capture     = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((start || continuous) && (ch_mask != '0)) start_sweep = 1'b1;
        end
        ST_CHARGE: begin
          if (cnt_q == CHARGE_LAST) begin
            state_d = ST_DECAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DECAY: begin
          if (all_done || timeout_hit) begin
            state_d = ST_DONE;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (continuous && (ch_mask != '0)) start_sweep = 1'b1;
          else                               state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (start_sweep) begin
        state_d = ST_CHARGE;
        cnt_d   = '0;
        mask_d  = ch_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      ttd_q   <= '0;
      tflag_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      // Results load on the DECAY->DONE edge, so the valid pulse is the
      // DONE cycle and the data is already stable while it is high.
      valid_q <= capture;
      if (capture) begin
        ttd_q   <= cap_d_flat;
        tflag_q <= tflag_d_vec;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    even_any = 1'b0;
    odd_any  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if ((i % 2) == 0) even_any = even_any | mask_q[i];
      else              odd_any  = odd_any  | mask_q[i];
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign sensor_oe     = (state_q == ST_CHARGE) ? mask_q : '0;
  assign led_even_en   = busy && even_any;
  assign led_odd_en    = busy && odd_any;
  assign ttd_flat      = ttd_q;
  assign timeout_flags = tflag_q;
  assign sample_valid  = valid_q;

endmodule

// File: tb/tb_qtr_array_reader.sv
// ---------------------------------------------------------------------------
// tb_qtr_array_reader
// Directed stimulus with a scoreboard. A behavioural pin model holds each
// channel high while driven and releases it a programmed number of cycles
// after sensor_oe drops. Expected sweep results are queued when a sweep is
// requested; a negedge monitor pops and compares on every sample_valid.
// ---------------------------------------------------------------------------
module tb_qtr_array_reader;

  localparam int N_CH        = 8;
  localparam int TTD_W       = 17;
  localparam int CHARGE_CYC  = 160;
  localparam int TIMEOUT_CYC = 48000;
  localparam int FLAT        = N_CH * TTD_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            start;
  logic            continuous;
  logic [N_CH-1:0] ch_mask;
  logic [N_CH-1:0] sensor_in = '0;
  logic [N_CH-1:0] sensor_oe;
  logic [FLAT-1:0] ttd_flat;
  logic [N_CH-1:0] timeout_flags;
  logic            sample_valid;
  logic            busy;
  logic            led_even_en;
  logic            led_odd_en;

  typedef struct packed {
    logic [FLAT-1:0] ttd;
    logic [N_CH-1:0] tf;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            s3_exp;
  int              checks    = 0;
  int              errors    = 0;
  int              valid_cnt = 0;
  int              oe_cnt    = 0;
  int              v0;
  logic [N_CH-1:0] oe_last   = '0;
  int              fall[N_CH];   // cycles after release until pin low; -1 = never
  int              ev[N_CH];     // expected ttd per channel for the next push
  int              ccnt[N_CH];
  logic [N_CH-1:0] lvl = '0;

  always #5 clk = ~clk;

  qtr_array_reader #(
    .N_CH        (N_CH),
    .TTD_W       (TTD_W),
    .CHARGE_CYC  (CHARGE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .start         (start),
    .continuous    (continuous),
    .ch_mask       (ch_mask),
    .sensor_in     (sensor_in),
    .sensor_oe     (sensor_oe),
    .ttd_flat      (ttd_flat),
    .timeout_flags (timeout_flags),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .led_even_en   (led_even_en),
    .led_odd_en    (led_odd_en)
  );

  // ---------------------------------------------------------------- checks
  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint req);
    checks++;
    if (act < req - 1 || act > req + 1) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/-1", name, act, req);
    end
  endtask

  // Unmasked (0) and timed-out results are exact; measured decays allow +/-1.
  task automatic cmp_result(input string tag, input exp_t e);
    int a, x;
    for (int i = 0; i < N_CH; i++) begin
      a = int'(ttd_flat[i*TTD_W +: TTD_W]);
      x = int'(e.ttd[i*TTD_W +: TTD_W]);
      if (x == 0 || x == TIMEOUT_CYC) check($sformatf("%s ttd%0d", tag, i), a, x);
      else                            check_near($sformatf("%s ttd%0d", tag, i), a, x);
    end
    check($sformatf("%s tflags", tag), timeout_flags, e.tf);
  endtask

  function automatic exp_t make_exp(input logic [N_CH-1:0] tf);
    exp_t e;
    e.tf = tf;
    for (int i = 0; i < N_CH; i++) e.ttd[i*TTD_W +: TTD_W] = TTD_W'(ev[i]);
    return e;
  endfunction

  task automatic push_exp(input logic [N_CH-1:0] tf);
    exp_q.push_back(make_exp(tf));
  endtask

  // ------------------------------------------------- pin model and monitor
  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (sensor_oe[i]) begin
        lvl[i]  = 1'b1;
        ccnt[i] = 0;
      end else if (lvl[i]) begin
        ccnt[i]++;
        if (fall[i] >= 0 && ccnt[i] > fall[i]) lvl[i] = 1'b0;
      end
    end
    sensor_in = lvl;
  end

  always @(negedge clk) begin
    if (|sensor_oe) begin
      oe_cnt++;
      oe_last = sensor_oe;
    end
    if (sample_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got a valid pulse, expected none (sweep %0d)", valid_cnt);
      end else begin
        cmp_result($sformatf("sweep%0d", valid_cnt), exp_q.pop_front());
      end
    end
  end

  // -------------------------------------------------------------- helpers
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < max_cyc && !seen; n++) begin
      @(negedge clk);
      seen = sample_valid;
    end
    check({name, " valid_seen"}, seen, 1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_CH; i++) begin
      fall[i] = -1;
      ev[i]   = 0;
    end
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; enable = 1'b0; start = 1'b0; continuous = 1'b0; ch_mask = '0;
    clear_model();
    #3;
    check("rst busy", busy, 0);
    check("rst oe", sensor_oe, 0);
    check("rst ttd_any", |ttd_flat, 0);
    check("rst tflags", timeout_flags, 0);
    check("rst valid", sample_valid, 0);
    check("rst leds", {led_even_en, led_odd_en}, 0);
    idle(3);
    rst = 1'b0; enable = 1'b1;
    idle(2);

    // 1: single-shot, all channels, staggered decays
    ch_mask = 8'hFF;
    for (int i = 0; i < N_CH; i++) begin
      fall[i] = 100 * (i + 1);
      ev[i]   = 100 * (i + 1) + 2;
    end
    push_exp('0);
    v0 = valid_cnt;
    pulse_start();
    wait_valid(1500, "t1");
    idle(20);
    check("t1 one_valid", valid_cnt - v0, 1);
    check("t1 idle_after", busy, 0);

    // 2: ch2 never decays -> timeout; even LED only
    clear_model();
    ch_mask = 8'h05;
    fall[0] = 100; ev[0] = 102;
    ev[2]   = TIMEOUT_CYC;
    push_exp(8'h04);
    pulse_start();
    idle(50);
    check("t2 charge leds", {led_even_en, led_odd_en}, 2'b10);
    idle(500);
    check("t2 decay busy", busy, 1);
    check("t2 decay leds", {led_even_en, led_odd_en}, 2'b10);
    wait_valid(TIMEOUT_CYC + 1000, "t2");
    idle(2);
    check("t2 idle leds", {led_even_en, led_odd_en}, 2'b00);

    // 3: continuous, three sweeps, mask change lands on the following sweep
    clear_model();
    ch_mask = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      fall[i] = 10 * (i + 1);
      ev[i]   = 10 * (i + 1) + 2;
    end
    push_exp('0);
    oe_cnt = 0;
    continuous = 1'b1;
    wait_valid(1000, "t3 s1");
    check("t3 s1 oe_cycles", oe_cnt, CHARGE_CYC);
    for (int i = 0; i < 4; i++) begin
      fall[i] = 50 - 10 * i;
      ev[i]   = 52 - 10 * i;
    end
    push_exp('0);
    idle(100);
    ch_mask = 8'h30;
    wait_valid(1000, "t3 s2");
    check("t3 s2 oe_cycles", oe_cnt, 2 * CHARGE_CYC);
    check("t3 s2 oe_mask", oe_last, 8'h0F);
    clear_model();
    fall[4] = 15; ev[4] = 17;
    fall[5] = 25; ev[5] = 27;
    s3_exp = make_exp('0);
    push_exp('0);
    wait_valid(1000, "t3 s3");
    continuous = 1'b0;
    check("t3 s3 oe_cycles", oe_cnt, 3 * CHARGE_CYC);
    check("t3 s3 oe_mask", oe_last, 8'h30);
    idle(5);
    check("t3 stops", busy, 0);

    // 4: enable dropped mid-DECAY -> abort, results held
    ch_mask = 8'hFF;
    for (int i = 0; i < N_CH; i++) fall[i] = 1000;
    v0 = valid_cnt;
    pulse_start();
    idle(CHARGE_CYC + 60);
    check("t4 in_sweep", busy, 1);
    enable = 1'b0;
    @(negedge clk);
    check("t4 abort busy", busy, 0);
    check("t4 abort oe", sensor_oe, 0);
    idle(1200);
    check("t4 no_valid", valid_cnt - v0, 0);
    cmp_result("t4 hold", s3_exp);
    enable = 1'b1;
    idle(2);

    // 5: start while busy is dropped; start with empty mask does nothing
    clear_model();
    ch_mask = 8'h01;
    fall[0] = 30; ev[0] = 32;
    push_exp('0);
    v0 = valid_cnt;
    pulse_start();
    idle(50);
    pulse_start();
    wait_valid(600, "t5");
    idle(300);
    check("t5 one_sweep", valid_cnt - v0, 1);
    check("t5 idle", busy, 0);
    ch_mask = '0;
    pulse_start();
    check("t5 mask0 busy", busy, 0);
    idle(200);
    check("t5 mask0 still_idle", busy, 0);
    check("t5 mask0 no_valid", valid_cnt - v0, 1);

    // 6: async reset mid-CHARGE, then a clean sweep
    ch_mask = 8'hFF;
    for (int i = 0; i < N_CH; i++) fall[i] = 50;
    pulse_start();
    idle(80);
    check("t6 charging oe", sensor_oe, 8'hFF);
    #3 rst = 1'b1;
    #1;
    check("t6 rst oe", sensor_oe, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst ttd_any", |ttd_flat, 0);
    check("t6 rst tflags", timeout_flags, 0);
    check("t6 rst leds", {led_even_en, led_odd_en}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    clear_model();
    ch_mask = 8'h03;
    fall[0] = 40; ev[0] = 42;
    fall[1] = 60; ev[1] = 62;
    push_exp('0);
    pulse_start();
    wait_valid(600, "t6");
    idle(5);
    check("scoreboard drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
